// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the pipeline control unit.
// No logic and no latency of its own; holds definitions used by the control-unit files.
// No flow control here; the hold/flush semantics live in pipe_hazard_ctrl.
package pipe_ctrl_pkg;

    localparam int REG_W_DEF   = 3;
    localparam int MULTI_N_DEF = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_MULTI = 1'b1
    } state_t;

    // Control word written into RR/EX on a bubble: every enable low.
    typedef struct packed {
        logic valid;
        logic rf_wr_en;
        logic mem_rd_en;
        logic mem_wr_en;
    } rr_ctrl_t;

    localparam rr_ctrl_t RR_CTRL_NOP = '0;

    // The micro-op ordinal counter gets one spare bit so that a full bitmap never wraps.
    function automatic int multi_off_width(input int multi_n);
        return $clog2(multi_n) + 1;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_lsb_first_enc.sv
// Lowest-set-bit encoder: index of the lowest set bit, the bitmap with that bit cleared, single-bit flag.
// Purely combinational, zero latency.
// No flow control; evaluates whatever bitmap it is given every cycle.
module lsb_first_enc #(
    parameter int N     = 8,
    parameter int IDX_W = 3
) (
    input  logic [N-1:0]     bitmap_i,
    output logic [IDX_W-1:0] idx_o,
    output logic [N-1:0]     rest_o,
    output logic             single_o
);

    // Scan from the top down so that the last hit, the lowest bit, wins.
    always_comb begin
        idx_o = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (bitmap_i[i]) begin
                idx_o = IDX_W'(i);
            end
        end
    end

    assign rest_o   = bitmap_i & (bitmap_i - N'(1));
    assign single_o = (|bitmap_i) & ~(|rest_o);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control: load-use stalls (only with HAZ_LOAD_USE_STALL_EN), EX redirect flushes, LM/SM micro-op sequencing.
// Outputs combinational from registered state and current inputs; a k-register LM/SM holds the front end for k cycles.
// Stalls hold IF and ID; bubble_rr injects a nop into RR/EX; ex_redirect overrides everything.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_W   = REG_W_DEF,
    parameter int MULTI_N = MULTI_N_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       id_valid,
    input  logic [REG_W-1:0]           id_src1,
    input  logic [REG_W-1:0]           id_src2,
    input  logic                       id_use1,
    input  logic                       id_use2,
    input  logic                       id_multi,
    input  logic [MULTI_N-1:0]         id_bitmap,
    input  logic                       rr_valid,
    input  logic                       rr_is_load,
    input  logic                       rr_wr_en,
    input  logic [REG_W-1:0]           rr_dest,
    input  logic                       ex_redirect,
    output logic                       stall_if,
    output logic                       stall_id,
    output logic                       bubble_rr,
    output logic                       flush_id,
    output logic                       flush_rr,
    output logic                       multi_busy,
    output logic [REG_W-1:0]           multi_reg,
    output logic [$clog2(MULTI_N):0]   multi_off,
    output logic                       multi_last
);

    localparam int OFF_W = multi_off_width(MULTI_N);

    state_t             state_q, state_d;
    logic [MULTI_N-1:0] pend_q, pend_d;
    logic [OFF_W-1:0]   off_q, off_d;

    logic [REG_W-1:0]   enc_idx;
    logic [MULTI_N-1:0] enc_rest;
    logic               enc_single;
    logic               load_use;
    logic               accept;

    lsb_first_enc #(
        .N     (MULTI_N),
        .IDX_W (REG_W)
    ) u_enc (
        .bitmap_i (pend_q),
        .idx_o    (enc_idx),
        .rest_o   (enc_rest),
        .single_o (enc_single)
    );

`ifdef HAZ_LOAD_USE_STALL_EN
    assign load_use = rr_valid & rr_is_load & rr_wr_en & id_valid &
                      ((id_use1 & (id_src1 == rr_dest)) |
                       (id_use2 & (id_src2 == rr_dest)));
`else
    // Compiler-scheduled code: the RR-side hazard inputs are intentionally ignored.
    logic unused_haz_in;
    assign unused_haz_in = ^{rr_valid, rr_is_load, rr_wr_en, rr_dest,
                             id_src1, id_src2, id_use1, id_use2};
    assign load_use = 1'b0;
`endif

    // An empty bitmap is not a sequence; it simply flows down the pipe as a nop.
    assign accept = id_valid & id_multi & (|id_bitmap);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pend_q  <= '0;
            off_q   <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            off_q   <= off_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        off_d   = off_q;
        if (ex_redirect) begin
            state_d = ST_IDLE;
            pend_d  = '0;
            off_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!load_use && accept) begin
                        state_d = ST_MULTI;
                        pend_d  = id_bitmap;
                        off_d   = '0;
                    end
                end
                ST_MULTI: begin
                    pend_d = enc_rest;
                    off_d  = off_q + OFF_W'(1);
                    if (enc_single) begin
                        state_d = ST_IDLE;
                        off_d   = '0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    pend_d  = '0;
                    off_d   = '0;
                end
            endcase
        end
    end

    // Reset forces every control low in the same cycle, whatever the state or inputs.
    always_comb begin
        stall_if   = 1'b0;
        stall_id   = 1'b0;
        bubble_rr  = 1'b0;
        flush_id   = 1'b0;
        flush_rr   = 1'b0;
        multi_busy = 1'b0;
        multi_reg  = '0;
        multi_off  = '0;
        multi_last = 1'b0;
        if (!rst) begin
            if (ex_redirect) begin
                flush_id = 1'b1;
                flush_rr = 1'b1;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (load_use || accept) begin
                            stall_if  = 1'b1;
                            stall_id  = 1'b1;
                            bubble_rr = 1'b1;
                        end
                    end
                    ST_MULTI: begin
                        multi_busy = 1'b1;
                        multi_reg  = enc_idx;
                        multi_off  = off_q;
                        multi_last = enc_single;
                        stall_if   = ~enc_single;
                        stall_id   = ~enc_single;
                    end
                    default: begin
                        stall_if = 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
